// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state and bypass-mux select encodings.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        MDU_BUSY = 2'b10
    } HazardState_t;

    typedef enum logic [1:0] {
        FWD_E_REG      = 2'b00,
        FWD_E_RESULT_W = 2'b01,
        FWD_E_ALU_M    = 2'b10
    } ForwardE_t;

    typedef enum logic {
        FWD_D_REG      = 1'b0,
        FWD_D_RESULT_W = 1'b1
    } ForwardD_t;

    // x0 is hardwired to zero, so a write to it never produces a usable bypass value.
    function automatic logic reg_match(input logic we, input logic [4:0] rd, input logic [4:0] rs);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// Combinational bypass-select logic for the D-stage (W->D) and E-stage (M/W->E) operand muxes.
module hazard_fwd_unit
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    output ForwardD_t  fwd_ad,
    output ForwardD_t  fwd_bd,
    output ForwardE_t  fwd_ae,
    output ForwardE_t  fwd_be
);

    always_comb begin
        fwd_ad = reg_match(RegWriteW, RdW, Rs1D) ? FWD_D_RESULT_W : FWD_D_REG;
        fwd_bd = reg_match(RegWriteW, RdW, Rs2D) ? FWD_D_RESULT_W : FWD_D_REG;

        // M holds the younger result, so it wins over W when both match.
        fwd_ae = FWD_E_REG;
        if (reg_match(RegWriteM, RdM, Rs1E))
            fwd_ae = FWD_E_ALU_M;
        else if (reg_match(RegWriteW, RdW, Rs1E))
            fwd_ae = FWD_E_RESULT_W;

        fwd_be = FWD_E_REG;
        if (reg_match(RegWriteM, RdM, Rs2E))
            fwd_be = FWD_E_ALU_M;
        else if (reg_match(RegWriteW, RdW, Rs2E))
            fwd_be = FWD_E_RESULT_W;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard scheduler: stall/flush enables, bypass selects, memory-wait and MDU sequencing.
// Optional HAZARD_PERF_EN adds 32-bit stall-cycle and branch-flush counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MDU_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteE,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        LoadE,
    input  logic        PCSrcE,
    input  logic        MemReqM,
    input  logic        MemReadyM,
    input  logic        MduStartE,
    input  logic        MduReady,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushM,
    output logic        ForwardAD,
    output logic        ForwardBD,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        MduTimeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] PerfStallCycles,
    output logic [31:0] PerfFlushCount
`endif
);

    localparam int CNT_W = $clog2(MDU_TIMEOUT + 1);

    HazardState_t state;
    HazardState_t state_nxt;
    logic [CNT_W-1:0] mdu_cnt;
    logic timeout_set;
    logic pc_flush;
    logic lw_stall;
    logic load_writes;

    ForwardD_t fwd_ad;
    ForwardD_t fwd_bd;
    ForwardE_t fwd_ae;
    ForwardE_t fwd_be;

    hazard_fwd_unit u_fwd (
        .Rs1D      (Rs1D),
        .Rs2D      (Rs2D),
        .Rs1E      (Rs1E),
        .Rs2E      (Rs2E),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .fwd_ad    (fwd_ad),
        .fwd_bd    (fwd_bd),
        .fwd_ae    (fwd_ae),
        .fwd_be    (fwd_be)
    );

    assign ForwardAD = reset ? 1'b0  : fwd_ad;
    assign ForwardBD = reset ? 1'b0  : fwd_bd;
    assign ForwardAE = reset ? 2'b00 : fwd_ae;
    assign ForwardBE = reset ? 2'b00 : fwd_be;

    // RegWriteE is implied for a load; the load-use check keys on LoadE and RdE alone.
    assign load_writes = LoadE | RegWriteE;
    assign lw_stall    = LoadE && load_writes && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

    // Mealy decode: a cycle that triggers a transition already drives the target state's controls.
    always_comb begin
        state_nxt   = state;
        timeout_set = 1'b0;
        pc_flush    = 1'b0;
        StallF      = 1'b0;
        StallD      = 1'b0;
        StallE      = 1'b0;
        StallM      = 1'b0;
        FlushD      = 1'b0;
        FlushE      = 1'b0;
        FlushM      = 1'b0;
        if (!reset) begin
            case (state)
                RUN: begin
                    if (MemReqM && !MemReadyM) begin
                        state_nxt = MEM_WAIT;
                        {StallF, StallD, StallE, StallM} = 4'b1111;
                    end else if (MduStartE) begin
                        state_nxt = MDU_BUSY;
                        {StallF, StallD, StallE, FlushM} = 4'b1111;
                    end else if (PCSrcE) begin
                        pc_flush = 1'b1;
                        FlushD   = 1'b1;
                        FlushE   = 1'b1;
                    end else if (lw_stall) begin
                        {StallF, StallD, FlushE} = 3'b111;
                    end
                end
                MEM_WAIT: begin
                    if (MemReadyM)
                        state_nxt = RUN;
                    else
                        {StallF, StallD, StallE, StallM} = 4'b1111;
                end
                MDU_BUSY: begin
                    if (MduReady) begin
                        state_nxt = RUN;
                    end else if (mdu_cnt == CNT_W'(MDU_TIMEOUT)) begin
                        state_nxt   = RUN;
                        timeout_set = 1'b1;
                    end else begin
                        {StallF, StallD, StallE, FlushM} = 4'b1111;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            mdu_cnt    <= '0;
            MduTimeout <= 1'b0;
        end else begin
            state      <= state_nxt;
            MduTimeout <= MduTimeout | timeout_set;
            if (state == MDU_BUSY)
                mdu_cnt <= mdu_cnt + 1'b1;
            else
                mdu_cnt <= '0;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            PerfStallCycles <= '0;
            PerfFlushCount  <= '0;
        end else begin
            PerfStallCycles <= PerfStallCycles + 32'(StallF);
            PerfFlushCount  <= PerfFlushCount + 32'(pc_flush);
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; a second instance with MDU_TIMEOUT=4 covers the abort path.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic RegWriteE, RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM, MduStartE, MduReady;

    logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, ForwardAD, ForwardBD, MduTimeout;
    logic [1:0] ForwardAE, ForwardBE;
    logic t_StallF, t_StallD, t_StallE, t_StallM, t_FlushD, t_FlushE, t_FlushM, t_ForwardAD, t_ForwardBD, t_MduTimeout;
    logic [1:0] t_ForwardAE, t_ForwardBE;
`ifdef HAZARD_PERF_EN
    logic [31:0] PerfStallCycles, PerfFlushCount, t_PerfStallCycles, t_PerfFlushCount;
`endif

    logic [6:0] ctl, t_ctl;
    logic [5:0] fwd;
    assign ctl   = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM};
    assign t_ctl = {t_StallF, t_StallD, t_StallE, t_StallM, t_FlushD, t_FlushE, t_FlushM};
    assign fwd   = {ForwardAD, ForwardBD, ForwardAE, ForwardBE};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .LoadE(LoadE), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM), .MduStartE(MduStartE),
        .MduReady(MduReady), .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MduTimeout(MduTimeout)
`ifdef HAZARD_PERF_EN
        , .PerfStallCycles(PerfStallCycles), .PerfFlushCount(PerfFlushCount)
`endif
    );

    pipeline_hazard_ctrl #(.MDU_TIMEOUT(4)) dut_t (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .LoadE(LoadE), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM), .MduStartE(MduStartE),
        .MduReady(MduReady), .StallF(t_StallF), .StallD(t_StallD), .StallE(t_StallE), .StallM(t_StallM),
        .FlushD(t_FlushD), .FlushE(t_FlushE), .FlushM(t_FlushM), .ForwardAD(t_ForwardAD), .ForwardBD(t_ForwardBD),
        .ForwardAE(t_ForwardAE), .ForwardBE(t_ForwardBE), .MduTimeout(t_MduTimeout)
`ifdef HAZARD_PERF_EN
        , .PerfStallCycles(t_PerfStallCycles), .PerfFlushCount(t_PerfFlushCount)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ctl order: StallF StallD StallE StallM FlushD FlushE FlushM
    task automatic check_ctl(input string tag, input logic [6:0] exp);
        check(tag, 32'(ctl), 32'(exp));
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {RegWriteE, RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM, MduStartE, MduReady} = '0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        tick();
        // Matching forward sources while in reset must still read as zero.
        RdM = 5'd5; RegWriteM = 1'b1; Rs1E = 5'd5; MemReqM = 1'b1;
        #1;
        check("reset_ctl", 32'(ctl), 32'd0);
        check("reset_fwd", 32'(fwd), 32'd0);
        tick();
        tick();
        clear_inputs();
        reset = 1'b0;
        #1;
        check("post_reset_ctl", 32'(ctl), 32'd0);
        check("post_reset_timeout", 32'(MduTimeout), 32'd0);
`ifdef HAZARD_PERF_EN
        check("post_reset_perf_stall", PerfStallCycles, 32'd0);
        check("post_reset_perf_flush", PerfFlushCount, 32'd0);
`endif

        // Forwarding
        RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5; Rs2E = 5'd3;
        Rs1D = 5'd5; Rs2D = 5'd6;
        #1;
        check("fwd_ae_m_prio", 32'(ForwardAE), 32'd2);
        check("fwd_be_none", 32'(ForwardBE), 32'd0);
        check("fwd_ad_w", 32'(ForwardAD), 32'd1);
        check("fwd_bd_none", 32'(ForwardBD), 32'd0);
        RegWriteM = 1'b0; Rs2E = 5'd5;
        #1;
        check("fwd_ae_w", 32'(ForwardAE), 32'd1);
        check("fwd_be_w", 32'(ForwardBE), 32'd1);
        RegWriteM = 1'b1; RdW = 5'd9; Rs2E = 5'd9;
        #1;
        check("fwd_be_w_only", 32'(ForwardBE), 32'd1);
        RdM = 5'd0; RdW = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0; Rs1D = 5'd0;
        #1;
        check("fwd_x0_never", 32'(fwd), 32'd0);
        check_ctl("fwd_no_ctl", 7'b0000000);
        tick();

        // Load-use stall: one cycle only
        clear_inputs();
        LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7; RegWriteE = 1'b1;
        #1;
        check_ctl("lw_stall", 7'b1100010);
        tick();
        clear_inputs();
        #1;
        check_ctl("lw_stall_release", 7'b0000000);
        LoadE = 1'b1; RdE = 5'd0; Rs1D = 5'd0;
        #1;
        check_ctl("lw_x0_no_stall", 7'b0000000);
        tick();

        // Branch flush beats load-use stall
        clear_inputs();
        LoadE = 1'b1; RdE = 5'd7; Rs1D = 5'd7; PCSrcE = 1'b1;
        #1;
        check_ctl("pcsrc_over_lw", 7'b0000110);
        tick();
        clear_inputs();
        #1;
        check_ctl("pcsrc_release", 7'b0000000);
`ifdef HAZARD_PERF_EN
        check("perf_stall_after_lw", PerfStallCycles, 32'd1);
        check("perf_flush_after_br", PerfFlushCount, 32'd1);
`endif

        // Data-memory wait: 3 stalled cycles, release on ready; branch mid-wait ignored
        MemReqM = 1'b1; MemReadyM = 1'b0; MduStartE = 1'b1;
        #1;
        check_ctl("mem_wait_c0_over_mdu", 7'b1111000);
        tick();
        MduStartE = 1'b0; PCSrcE = 1'b1;
        #1;
        check_ctl("mem_wait_c1_pcsrc", 7'b1111000);
        tick();
        PCSrcE = 1'b0;
        #1;
        check_ctl("mem_wait_c2", 7'b1111000);
        tick();
        MemReadyM = 1'b1;
        #1;
        check_ctl("mem_ready", 7'b0000000);
        tick();
        clear_inputs();
        #1;
        check_ctl("mem_back_run", 7'b0000000);
        tick();

        // MDU: ready after 10 cycles on dut; dut_t (timeout 4) aborts on cycle 5
        MduStartE = 1'b1;
        #1;
        check_ctl("mdu_c0", 7'b1110001);
        for (int c = 1; c <= 9; c++) begin
            tick();
            MduStartE = 1'b0;
            PCSrcE = (c == 3);
            #1;
            check_ctl($sformatf("mdu_c%0d", c), 7'b1110001);
            if (c <= 4) begin
                check($sformatf("tmo_busy_c%0d", c), 32'(t_ctl), 32'b1110001);
                check($sformatf("tmo_flag_c%0d", c), 32'(t_MduTimeout), 32'd0);
            end else if (c == 5) begin
                check("tmo_abort_ctl", 32'(t_ctl), 32'd0);
            end else begin
                check($sformatf("tmo_flag_c%0d", c), 32'(t_MduTimeout), 32'd1);
            end
        end
        tick();
        MduReady = 1'b1;
        #1;
        check_ctl("mdu_ready", 7'b0000000);
        tick();
        clear_inputs();
        #1;
        check_ctl("mdu_back_run", 7'b0000000);
        check("mdu_no_timeout", 32'(MduTimeout), 32'd0);
        check("tmo_sticky", 32'(t_MduTimeout), 32'd1);
        tick();

        // Reset pulsed in MEM_WAIT
        MemReqM = 1'b1; MemReadyM = 1'b0;
        tick();
        #1;
        check_ctl("rst_pre_mem_wait", 7'b1111000);
        reset = 1'b1;
        #1;
        check_ctl("rst_in_mem_wait", 7'b0000000);
        tick();
        reset = 1'b0; MemReqM = 1'b0;
        #1;
        check_ctl("rst_back_run", 7'b0000000);
        check("rst_clears_timeout", 32'(t_MduTimeout), 32'd0);
`ifdef HAZARD_PERF_EN
        check("rst_perf_stall_zero", PerfStallCycles, 32'd0);
        check("rst_perf_flush_zero", PerfFlushCount, 32'd0);
        MemReqM = 1'b1;
        tick();
        tick();
        MemReqM = 1'b0; MemReadyM = 1'b1;
        tick();
        #1;
        check("perf_stall_two", PerfStallCycles, 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
